buzzer_pattern_decoder: RTL
===========================

BUZZER_PATTERN_DECODER -- requirements
Module: buzzer_pattern_decoder

Interface
REQ-001 Parameter HALF_MIN, default 3000: minimum accepted tone half-period, in clk cycles since the previous edge.
REQ-002 Parameter HALF_MAX, default 3300: maximum accepted tone half-period, in clk cycles.
REQ-003 Parameter LOCK_HALVES, default 4: consecutive valid edges needed to declare a tone present.
REQ-004 Parameter BEEP_MIN, default 1_258_750: minimum tone-active cycles (50 ms at 25.175 MHz) for a beep to count.
REQ-005 Parameter BURST_GAP, default 5_035_000: silence cycles (200 ms) that close a burst.
REQ-006 Port clk, input, 1: single system clock; the block SHALL use one clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: reset; synchronous, active-high.
REQ-008 Port tone_i, input, 1: asynchronous buzzer square-wave input.
REQ-009 Port tone_active, output, 1: high while state is BEEP.
REQ-010 Port evt_valid, output, 1: one-cycle pulse when a burst is closed.
REQ-011 Port evt_count, output, 3: beeps in the closed burst, saturating at 7.
REQ-012 Port evt_eat, output, 1: set when evt_count==1.
REQ-013 Port evt_game_over, output, 1: set when evt_count==3.

Function
REQ-014 tone_i SHALL pass through a 2-FF synchronizer; edge = sync output XOR its 1-cycle delayed copy.
REQ-015 half_cnt (16 bit) SHALL increment every cycle without an edge, saturating at 0xFFFF, and SHALL clear to 0 on every edge, in all states.
REQ-016 valid_edge = edge AND HALF_MIN <= half_cnt <= HALF_MAX, with half_cnt sampled before clearing.
REQ-017 lost = (edge AND NOT valid_edge) OR (no edge AND half_cnt == HALF_MAX+1).
REQ-018 States: IDLE, LOCK, BEEP, GAP; reset state IDLE.
REQ-019 IDLE: valid_edge -> LOCK with lock_cnt=1. All other inputs hold IDLE. gap_timer is not running.
REQ-020 LOCK: valid_edge increments lock_cnt; on reaching LOCK_HALVES -> BEEP with beep_len=0. lost -> IDLE if burst_cnt==0, else GAP.
REQ-021 BEEP: beep_len increments, saturating at 32 bits. On lost: if beep_len >= BEEP_MIN, burst_cnt increments (saturating at 7).
REQ-022 BEEP on lost (continued): gap_timer clears to 0; next state is GAP if the updated burst_cnt > 0, else IDLE (a short glitch with an empty burst is discarded).
REQ-023 GAP: valid_edge -> LOCK with lock_cnt=1.
REQ-024 gap_timer SHALL increment in LOCK and GAP while burst_cnt > 0.
REQ-025 On gap_timer reaching BURST_GAP, in GAP or LOCK:
- pulse evt_valid for 1 cycle;
- load evt_count = burst_cnt, with evt_eat and evt_game_over decoded from it;
- clear burst_cnt;
- GAP -> IDLE; LOCK stays in LOCK (acquisition continues for a new burst).
REQ-026 A lost in BEEP in the same cycle as a gap timeout is impossible (gap_timer does not run in BEEP); a valid_edge in GAP in the timeout cycle SHALL emit the event and also enter LOCK.
REQ-027 evt_count, evt_eat and evt_game_over SHALL be registered and hold until the next evt_valid. No backpressure: the consumer must sample on evt_valid.
REQ-028 Latency: evt_valid rises exactly BURST_GAP+1 cycles after the cycle in which the last beep's lost is detected.
REQ-029 Counts of 2 or of 4-7 SHALL give evt_eat=0 and evt_game_over=0.

Reset
REQ-030 rst high at a clock edge SHALL give state IDLE, all counters 0, synchronizer flops 0, and all outputs 0 on the next cycle.
REQ-031 rst mid-burst SHALL discard the burst with no evt_valid; rst has priority over all other logic.

Verification
Test parameters: HALF_MIN=8, HALF_MAX=12, LOCK_HALVES=4, BEEP_MIN=200, BURST_GAP=500. Source toggles every 10 cycles.
REQ-032 One 400-cycle tone burst, then silence -> exactly one evt_valid with evt_count=1, evt_eat=1, evt_game_over=0; tone_active high for the beep only.
REQ-033 Three 400-cycle beeps separated by 300-cycle gaps -> one evt_valid with evt_count=3, evt_game_over=1, evt_eat=0.
REQ-034 Tone toggling every 20 cycles (out of window) for 1000 cycles -> tone_active never high, no evt_valid.
REQ-035 100-cycle tone (below BEEP_MIN) -> no evt_valid; state returns to IDLE.
REQ-036 rst asserted 150 cycles into the second beep of a 3-beep pattern -> outputs 0 the next cycle, no evt_valid; a following single beep yields evt_count=1.
REQ-037 Eight 400-cycle beeps with 300-cycle gaps -> evt_count=7 (saturated), evt_eat=0, evt_game_over=0.

Source files
------------

// File: rtl/buzzer_pattern_decoder.sv
// buzzer_pattern_decoder: locks onto a buzzer square wave, measures beeps and reports the beep count of each burst
module buzzer_pattern_decoder #(
  parameter int HALF_MIN = 3000,
  parameter int HALF_MAX = 3300,
  parameter int LOCK_HALVES = 4,
  parameter int BEEP_MIN = 1_258_750,
  parameter int BURST_GAP = 5_035_000
) (
  input logic clk,
  input logic rst,
  input logic tone_i,
  output logic tone_active,
  output logic evt_valid,
  output logic [2:0] evt_count,
  output logic evt_eat,
  output logic evt_game_over
);
  typedef enum logic [1:0] {IDLE, LOCK, BEEP, GAP} state_t;
  state_t state;
  logic s1, s2, s3;
  logic [15:0] half_cnt;
  logic [15:0] lock_cnt;
  logic [31:0] beep_len;
  logic [31:0] gap_timer;
  logic [2:0] burst_cnt;
  logic [2:0] burst_next;
  logic tone_edge, valid_edge, lost, timeout, gap_run;
  always_comb begin
    tone_active = state == BEEP;
    tone_edge = s2 ^ s3;
    valid_edge = tone_edge && half_cnt >= 16'(HALF_MIN) && half_cnt <= 16'(HALF_MAX);
    lost = tone_edge ? !valid_edge : half_cnt == 16'(HALF_MAX + 1);
    gap_run = (state == LOCK || state == GAP) && burst_cnt != 3'd0;
    timeout = gap_run && gap_timer == 32'(BURST_GAP - 1);
    burst_next = (beep_len >= 32'(BEEP_MIN) && burst_cnt != 3'd7) ? burst_cnt + 3'd1 : burst_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {s3, s2, s1} <= 3'b000;
      half_cnt <= '0;
      lock_cnt <= '0;
      beep_len <= '0;
      gap_timer <= '0;
      burst_cnt <= '0;
      evt_valid <= 1'b0;
      evt_count <= '0;
      evt_eat <= 1'b0;
      evt_game_over <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, tone_i};
      half_cnt <= tone_edge ? '0 : (half_cnt == 16'hFFFF ? half_cnt : half_cnt + 16'd1);
      evt_valid <= timeout;
      if (gap_run) gap_timer <= gap_timer + 32'd1;
      if (timeout) begin
        evt_count <= burst_cnt;
        evt_eat <= burst_cnt == 3'd1;
        evt_game_over <= burst_cnt == 3'd3;
        burst_cnt <= '0;
      end
      case (state)
        IDLE: if (valid_edge) begin
          state <= LOCK;
          lock_cnt <= 16'd1;
        end
        LOCK: if (valid_edge) begin
          lock_cnt <= lock_cnt + 16'd1;
          if (lock_cnt + 16'd1 == 16'(LOCK_HALVES)) begin
            state <= BEEP;
            beep_len <= '0;
          end
        end else if (lost) state <= (burst_cnt == 3'd0 || timeout) ? IDLE : GAP;
        BEEP: begin
          beep_len <= beep_len == 32'hFFFF_FFFF ? beep_len : beep_len + 32'd1;
          if (lost) begin
            burst_cnt <= burst_next;
            gap_timer <= '0;
            state <= burst_next != 3'd0 ? GAP : IDLE;
          end
        end
        GAP: if (valid_edge) begin
          state <= LOCK;
          lock_cnt <= 16'd1;
        end else if (timeout) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
